// File: rtl/fifo_nibble_serializer_pkg.sv
// fifo_ser_pkg: shared definitions for the FIFO nibble serializer.
//   state_e    - FSM state encoding (exported on the top's dbg_state port)
//   DEF_DATA_W - default nibble width
//   DEF_DIV    - default clocks per serial bit
//   frame_len  - clocks of tx activity per frame (start + data + parity + stop)
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DIV    = 4;

  function automatic int frame_len(input int data_w, input int div, input int parity_en);
    return (2 + data_w + parity_en) * div;
  endfunction

endpackage

// File: rtl/fifo_nibble_serializer_bit_timer.sv
// ser_bit_timer: counts clocks within one serial bit period.
//   clk, rst    - clock, asynchronous active-low reset
//   restart     - forces the count back to 0 on the next edge
//   last_cycle  - current cycle is the final cycle of the bit period
//   last_next   - the coming cycle will be the final cycle of the bit period
module ser_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic last_cycle,
  output logic last_next
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // With DIV=1 LAST is 0, so every cycle is the last one: no dead cycles.
  assign last_cycle = (cnt_q == LAST);
  assign last_next  = (cnt_d == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_nibble_serializer.sv
// fifo_nibble_serializer: drains nibbles from a FIFO read port and sends each
// one as a framed LSB-first serial stream: start(0), data, optional even
// parity, stop(1). Every bit is held for DIV clocks.
//   clk, rst    - clock, asynchronous active-low reset
//   enable      - allows new frames (looked at in IDLE and last STOP cycle)
//   fifo_empty  - FIFO empty flag
//   fifo_data   - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  - one-cycle read strobe
//   tx_out      - serial line, idles high
//   busy        - state is not IDLE
//   frame_done  - pulse on the final cycle of the stop bit
//   dbg_state   - current FSM state
//
// FIFO read handshake: a read is issued only after fifo_empty=0 was sampled
// in IDLE or on the last STOP cycle; fifo_rd_en is high for exactly the READ
// cycle and the data is taken unconditionally during the following LOAD cycle.
module fifo_nibble_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DIV       = DEF_DIV,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              rd_q, rd_d;
  logic              done_q, done_d;
  logic              in_bit_state;
  logic              last_cycle;
  logic              last_next;

  assign in_bit_state = (state_q == START) || (state_q == DATA) ||
                        (state_q == PARITY) || (state_q == STOP);

  // Held at 0 outside bit states so the first START cycle starts a full period.
  ser_bit_timer #(.DIV(DIV)) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .restart    (!in_bit_state || last_cycle),
    .last_cycle (last_cycle),
    .last_next  (last_next)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) state_d = READ;
      end
      READ: state_d = LOAD;
      LOAD: begin
        shift_d = fifo_data;
        bit_d   = '0;
        par_d   = 1'b0;
        state_d = START;
      end
      START: begin
        if (last_cycle) state_d = DATA;
      end
      DATA: begin
        if (last_cycle) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (last_cycle) state_d = STOP;
      end
      STOP: begin
        if (last_cycle) state_d = (enable && !fifo_empty) ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge
  // as the state itself.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    rd_d   = (state_d == READ);
    done_d = (state_d == STOP) && last_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign tx_out     = tx_q;
  assign fifo_rd_en = rd_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_nibble_serializer.sv
// Bench for fifo_nibble_serializer. Three instances cover DIV=2/parity,
// DIV=2/no parity and DIV=1/parity; sel routes the shared FIFO model and
// the monitored outputs to one instance while the others sit idle.
module tb_fifo_nibble_serializer;
  import fifo_ser_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       enable = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_data = 4'h0;

  logic       en [3];
  logic       fe [3];
  logic       rd [3];
  logic       tx [3];
  logic       bz [3];
  logic       fd [3];
  logic [2:0] st [3];

  for (genvar k = 0; k < 3; k++) begin : g_route
    assign en[k] = enable && (sel == 2'(k));
    assign fe[k] = (sel == 2'(k)) ? fifo_empty : 1'b1;
  end

  fifo_nibble_serializer #(.DATA_W(4), .DIV(2), .PARITY_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(fe[0]), .fifo_data(fifo_data),
    .fifo_rd_en(rd[0]), .tx_out(tx[0]), .busy(bz[0]), .frame_done(fd[0]), .dbg_state(st[0]));

  fifo_nibble_serializer #(.DATA_W(4), .DIV(2), .PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(fe[1]), .fifo_data(fifo_data),
    .fifo_rd_en(rd[1]), .tx_out(tx[1]), .busy(bz[1]), .frame_done(fd[1]), .dbg_state(st[1]));

  fifo_nibble_serializer #(.DATA_W(4), .DIV(1), .PARITY_EN(1'b1)) u_dut_d1 (
    .clk(clk), .rst(rst), .enable(en[2]), .fifo_empty(fe[2]), .fifo_data(fifo_data),
    .fifo_rd_en(rd[2]), .tx_out(tx[2]), .busy(bz[2]), .frame_done(fd[2]), .dbg_state(st[2]));

  logic       m_rd, m_tx, m_bz, m_fd;
  logic [2:0] m_st;
  assign m_rd = rd[sel];
  assign m_tx = tx[sel];
  assign m_bz = bz[sel];
  assign m_fd = fd[sel];
  assign m_st = st[sel];

  function automatic int div_of(input logic [1:0] s);
    return (s == 2'd2) ? 1 : 2;
  endfunction

  function automatic int par_of(input logic [1:0] s);
    return (s == 2'd1) ? 0 : 1;
  endfunction

  // FIFO model: registered empty flag, data valid the cycle after the strobe
  logic [3:0] fq[$];
  int rd_cnt = 0;
  int underflow = 0;
  always @(posedge clk) begin
    if (m_rd) begin
      rd_cnt++;
      if (fifo_empty) underflow++;
      else fifo_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // scoreboard
  logic [3:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] n);
    fq.push_back(n);
    exp_q.push_back(n);
  endtask

  // Expects the current sample to be the first START cycle (or within max_wait).
  task automatic check_frame(input int max_wait, input int drop_at);
    logic [3:0] nib;
    logic       eb;
    int div, par, len, w, b;
    div = div_of(sel);
    par = par_of(sel);
    len = (2 + 4 + par) * div;
    nib = (exp_q.size() != 0) ? exp_q.pop_front() : 4'h0;
    w = 0;
    while (m_tx !== 1'b0 && w < max_wait) begin
      @(negedge clk);
      w++;
    end
    chk("frame_start", m_tx, 0);
    if (m_tx === 1'b0) begin
      for (int i = 0; i < len; i++) begin
        b = i / div;
        if (b == 0) eb = 1'b0;
        else if (b <= 4) eb = nib[b-1];
        else if (b == 5 && par == 1) eb = ^nib;
        else eb = 1'b1;
        chk($sformatf("tx_bit[%0d] nib %0h", i, nib), m_tx, eb);
        chk($sformatf("frame_done[%0d]", i), m_fd, (i == len - 1));
        chk($sformatf("busy[%0d]", i), m_bz, 1);
        if (i == drop_at) enable = 1'b0;
        if (i != len - 1) @(negedge clk);
      end
    end
  endtask

  task automatic wait_read(input int lead);
    for (int j = 1; j < lead; j++) begin
      @(negedge clk);
      chk("idle_rd", m_rd, 0);
    end
    @(negedge clk);
    chk("read_rd", m_rd, 1);
    chk("read_busy", m_bz, 1);
  endtask

  task automatic burst(input int lead, input int nfr, input int drop_at);
    int rd0;
    rd0 = rd_cnt;
    wait_read(lead);
    @(negedge clk);
    chk("load_rd", m_rd, 0);
    chk("load_tx", m_tx, 1);
    @(negedge clk);
    check_frame(0, drop_at);
    for (int f = 1; f < nfr; f++) begin
      @(negedge clk);
      chk("gap_read_rd", m_rd, 1);
      chk("gap_read_tx", m_tx, 1);
      @(negedge clk);
      chk("gap_load_rd", m_rd, 0);
      chk("gap_load_tx", m_tx, 1);
      @(negedge clk);
      check_frame(0, -1);
    end
    @(negedge clk);
    chk("post_busy", m_bz, 0);
    chk("post_tx", m_tx, 1);
    chk("read_count", 8'(rd_cnt - rd0), 8'(nfr));
  endtask

  task automatic idle_cycles(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      chk("idle_rd", m_rd, 0);
      chk("idle_tx", m_tx, 1);
      chk("idle_busy", m_bz, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    logic [3:0] n;

    // reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_tx", m_tx, 1);
    chk("rst_busy", m_bz, 0);
    chk("rst_rd", m_rd, 0);
    chk("rst_fd", m_fd, 0);
    chk("rst_state", m_st, IDLE);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // empty FIFO with enable high: no reads, line idle
    enable = 1'b1;
    idle_cycles(50);

    // single frames
    push(4'hA);
    burst(2, 1, -1);
    push(4'h7);
    burst(2, 1, -1);

    // back-to-back
    push(4'h3);
    push(4'hC);
    burst(2, 2, -1);

    // random bursts
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) push(4'($urandom));
      burst(2, k, -1);
    end

    // enable dropped mid-frame: frame completes, queued nibble stays put
    push(4'($urandom));
    push(4'($urandom));
    burst(2, 1, 5);
    idle_cycles(20);
    enable = 1'b1;
    burst(1, 1, -1);

    // no parity
    sel = 2'd1;
    push(4'h7);
    burst(2, 1, -1);
    push(4'($urandom));
    push(4'($urandom));
    burst(2, 2, -1);

    // DIV=1
    sel = 2'd2;
    push(4'h5);
    burst(2, 1, -1);
    push(4'($urandom));
    push(4'($urandom));
    burst(2, 2, -1);

    // reset mid-DATA
    sel = 2'd0;
    n = 4'($urandom) & 4'hE;
    push(n);
    wait_read(2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_data_tx", m_tx, 0);
    chk("mid_data_state", m_st, DATA);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", m_tx, 1);
    chk("async_rst_busy", m_bz, 0);
    chk("async_rst_rd", m_rd, 0);
    chk("async_rst_fd", m_fd, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(10);
    chk("post_rst_state", m_st, IDLE);
    push(4'($urandom));
    burst(2, 1, -1);

    chk("underflow", 8'(underflow), 0);
    chk("exp_q_drained", 8'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_nibble_serializer.md
# fifo_nibble_serializer

Downstream consumer for the 4-deep × 4-bit FIFO. It drains one nibble at a time through the FIFO's read port and transmits each nibble as a framed, LSB-first serial bit stream: start bit, data bits, optional even parity, stop bit. It is the bridge between the FIFO buffer and a 1-wire output pin. Each bit is held for a programmable number of clocks.

## Interface
Parameters:
- DATA_W, 4: nibble width; must match the FIFO data width.
- DIV, 4: clocks per serial bit; legal range is 1 or more.
- PARITY_EN, 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low; assertion clears all state immediately.
- enable  in  1  permits starting new frames; sampled only in IDLE and on the last STOP cycle.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_W  FIFO data_out; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  one-cycle read strobe to the FIFO.
- tx_out  out  1  serial line; idles high.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-cycle pulse on the final cycle of STOP.

## Operation
- The FSM states are IDLE, READ, LOAD, START, DATA, PARITY and STOP.
- IDLE: if enable=1 and fifo_empty=0, go to READ. Otherwise stay in IDLE.
- READ: fifo_rd_en=1 for exactly this one cycle. Go to LOAD.
- LOAD: capture fifo_data into the shift register. Clear the parity accumulator and bit counters. Go to START.
- START: tx_out=0 for DIV cycles. Then go to DATA.
- DATA: drive the shift register LSB on tx_out for DIV cycles, then shift right. Accumulate parity as the XOR of the data bits. After DATA_W bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: tx_out = XOR of the data bits (even parity) for DIV cycles. Go to STOP.
- STOP: tx_out=1 for DIV cycles. On the last cycle, frame_done=1. The next state is decided on that last cycle:
  - enable=1 and fifo_empty=0: go to READ (back-to-back frames).
  - otherwise: go to IDLE.
- fifo_rd_en is never asserted while fifo_empty=1 is being sampled; the block never underflows the FIFO.
- Deasserting enable mid-frame does not abort the frame. The current frame completes and no new frame starts.
- A change on fifo_empty after READ has no effect on the frame in flight.
- Reset asserted mid-frame: tx_out returns to 1 asynchronously, and the partial frame is discarded. The consumed nibble is lost; this is acceptable.

## Timing
- Reset values: state=IDLE, tx_out=1, fifo_rd_en=0, busy=0, frame_done=0, and all counters and the shift register are 0.
- tx_out, fifo_rd_en and frame_done are registered; each changes on the same edge on which the state changes.
- Start-up latency: if IDLE samples the start condition at edge E, READ occupies E..E+1, LOAD occupies E+1..E+2, and tx_out falls at E+2.
- Frame length: (2 + DATA_W + PARITY_EN) × DIV cycles of tx activity. With the defaults this is 28 cycles.
- Back-to-back frames are separated by exactly 2 extra tx_out=1 cycles (READ and LOAD).
- The bit-period counter is $clog2(DIV) bits wide, with a minimum width of 1, and wraps at DIV-1. DIV=1 must give one clock per bit with no dead cycles.
- The data-bit counter is $clog2(DATA_W) bits wide, with a minimum width of 1.

## Structure
- Package fifo_ser_pkg holds:
  - the state enum: IDLE, READ, LOAD, START, DATA, PARITY, STOP;
  - the default DATA_W and DIV localparams;
  - a frame-length helper function.
- Sub-module ser_bit_timer: a DIV-cycle counter with a restart input and a last_cycle output. It is instantiated once and restarted on entry to every bit state.
- The top level contains the FSM, shift register, parity accumulator and output registers.

## Test plan
Unless stated otherwise, tests use DIV=2, PARITY_EN=1, DATA_W=4.
- Reset check: assert rst low mid-DATA → tx_out=1, busy=0 and fifo_rd_en=0 immediately. After release, the state is IDLE and nothing is transmitted until fifo_empty=0.
- Single frame: nibble 4'hA, enable=1 → fifo_rd_en pulses 1 cycle, and tx_out = 0,0 | 0,0 1,1 0,0 1,1 | 0,0 | 1,1 (start, LSB-first 0101, parity 0, stop). frame_done pulses on cycle 14 of the frame.
- Parity: nibble 4'h7 → data bits 1,1,1,0 followed by parity bit 1. With PARITY_EN=0 the frame is 12 cycles with no parity bit.
- Back-to-back: FIFO holds 4'h3 and 4'hC → two frames with exactly 2 high cycles between the first stop bit's end and the second start bit, and exactly two fifo_rd_en pulses.
- Empty / enable gating: with fifo_empty=1 for 50 cycles, fifo_rd_en stays 0 and tx_out stays 1. Dropping enable mid-frame lets the frame complete, with no further reads.
- DIV=1: nibble 4'h5 → a 7-cycle frame 0,1,0,1,0,0,1 with no idle gaps inside the frame.
